ppu_sparse_compressor: RTL and testbench



---
 rtl/ppu_sparse_compressor_pkg.sv | 38 +++
 rtl/ppu_sparse_compressor_if.sv | 28 ++
 rtl/ppu_sparse_compressor_lane_compactor.sv | 66 ++++++
 rtl/ppu_sparse_compressor.sv | 173 +++++++++++++++++
 tb/tb_ppu_sparse_compressor.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ppu_sparse_compressor_pkg.sv
// Shared types and constants for the PPU sparse compressor slice.
package ppu_sparse_compressor_pkg;

   localparam int unsigned POOLING_OUT_SIZE            = 4;
   localparam int unsigned PPU_DATA_W                  = 16;
   localparam int unsigned PPU_RUN_WIDTH               = 4;
   localparam int unsigned PPU_NNZ_W                   = 16;
   localparam int unsigned ACCUMULATOR_BUFFER_K_OFFSET = 64;
   localparam int unsigned PPU_KC_W                    = $clog2(ACCUMULATOR_BUFFER_K_OFFSET);
   localparam int unsigned PPU_CNT_W                   = $clog2(POOLING_OUT_SIZE + 1);

   // Pooled packet as produced by the pooling stage.
   typedef struct packed {
      logic [POOLING_OUT_SIZE-1:0]                 valid;
      logic [POOLING_OUT_SIZE-1:0][PPU_DATA_W-1:0] data;
   } PPU_compress_PACKET;

   // One sparse entry: nonzero value plus the zero run preceding it.
   typedef struct packed {
      logic [PPU_DATA_W-1:0]    data;
      logic [PPU_RUN_WIDTH-1:0] run;
   } PPU_COMP_ENTRY;

   // Compacted entries, occupying lanes 0..cnt-1.
   typedef struct packed {
      logic [POOLING_OUT_SIZE-1:0]                    valid;
      logic [POOLING_OUT_SIZE-1:0][PPU_DATA_W-1:0]    data;
      logic [POOLING_OUT_SIZE-1:0][PPU_RUN_WIDTH-1:0] run;
   } PPU_COMP_OUT_PACKET;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_CLOSE,
      ST_DONE
   } comp_state_t;

endpackage

// File: rtl/ppu_sparse_compressor_if.sv
// Pooling-side input bus and compressed-output bus of the sparse compressor.
interface ppu_sparse_compressor_if
   import ppu_sparse_compressor_pkg::*;
   ();

   PPU_compress_PACKET        pool_in;
   logic [PPU_KC_W-1:0]       pool_kc;
   logic                      pool_finish;

   PPU_COMP_OUT_PACKET        comp_out;
   logic [PPU_CNT_W-1:0]      comp_cnt;
   logic                      chan_done;
   logic [PPU_KC_W-1:0]       chan_kc;
   logic [PPU_NNZ_W-1:0]      chan_nnz;
   logic                      compress_done;
   logic                      proto_err;

   modport master (
      output pool_in, pool_kc, pool_finish,
      input  comp_out, comp_cnt, chan_done, chan_kc, chan_nnz, compress_done, proto_err
   );

   modport slave (
      input  pool_in, pool_kc, pool_finish,
      output comp_out, comp_cnt, chan_done, chan_kc, chan_nnz, compress_done, proto_err
   );

endinterface

// File: rtl/ppu_sparse_compressor_lane_compactor.sv
// Combinational lane encoder: walks lanes in order carrying the zero run,
// emits entries and packs them into the low output lanes.
module ppu_lane_compactor
   import ppu_sparse_compressor_pkg::*;
#(
   parameter int unsigned LANES  = POOLING_OUT_SIZE,
   parameter int unsigned DATA_W = PPU_DATA_W,
   parameter int unsigned RUN_W  = PPU_RUN_WIDTH,
   parameter int unsigned CNT_W  = PPU_CNT_W
) (
   input  PPU_compress_PACKET  pkt,
   input  logic [RUN_W-1:0]    zrun_in,
   output PPU_COMP_OUT_PACKET  ent,
   output logic [CNT_W-1:0]    cnt,
   output logic [RUN_W-1:0]    zrun_out
);

   localparam int unsigned      IDX_W   = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [RUN_W-1:0] MAX_RUN = '1;

   PPU_COMP_ENTRY      e;
   logic               emit;
   logic [DATA_W-1:0]  d;
   logic [RUN_W-1:0]   z;
   logic [CNT_W-1:0]   n;

   // The running count n is the prefix sum of emits so far and is the slot
   // the next emitted entry lands in.
   always_comb begin
      ent  = '0;
      z    = zrun_in;
      n    = '0;
      e    = '0;
      emit = 1'b0;
      d    = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         emit = 1'b0;
         e    = '0;
         d    = pkt.data[i];
         if (pkt.valid[i]) begin
            if (d != '0) begin
               e.data = d;
               e.run  = z;
               emit   = 1'b1;
               z      = '0;
            end else if (z == MAX_RUN) begin
               e.data = '0;
               e.run  = MAX_RUN;
               emit   = 1'b1;
               z      = '0;
            end else begin
               z = z + RUN_W'(1);
            end
         end
         if (emit) begin
            ent.valid[n[IDX_W-1:0]] = 1'b1;
            ent.data[n[IDX_W-1:0]]  = e.data;
            ent.run[n[IDX_W-1:0]]   = e.run;
            n = n + CNT_W'(1);
         end
      end
      cnt      = n;
      zrun_out = z;
   end

endmodule

// File: rtl/ppu_sparse_compressor.sv
// Re-encodes pooled packets into SCNN sparse entries with per-channel
// nonzero counts and a layer completion pulse.
module ppu_sparse_compressor
   import ppu_sparse_compressor_pkg::*;
#(
   parameter int unsigned LANES  = POOLING_OUT_SIZE,
   parameter int unsigned DATA_W = PPU_DATA_W,
   parameter int unsigned RUN_W  = PPU_RUN_WIDTH,
   parameter int unsigned NNZ_W  = PPU_NNZ_W,
   parameter int unsigned KC_W   = PPU_KC_W
) (
   input  logic                    clk,
   input  logic                    rst,
   ppu_sparse_compressor_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(LANES + 1);

   comp_state_t         state, state_n;
   logic [RUN_W-1:0]    zrun, zrun_n, zrun_base, zrun_enc;
   logic [NNZ_W-1:0]    nnz, nnz_n, nnz_base, nnz_acc;
   logic [NNZ_W:0]      nnz_sum;
   logic                nnz_sat;
   logic [KC_W-1:0]     cur_kc, cur_kc_n;

   PPU_compress_PACKET  enc_in;
   PPU_COMP_OUT_PACKET  enc_out, comp_out_n;
   logic [CNT_W-1:0]    enc_cnt, comp_cnt_n;

   logic                active, take, kc_change;
   logic                chan_done_n, compress_done_n, err_set;
   logic [KC_W-1:0]     chan_kc_n;
   logic [NNZ_W-1:0]    chan_nnz_n;

   assign active = |bus.pool_in.valid;

   // Decide whether this packet is encoded and which run/count it builds on;
   // a channel change restarts both before the new packet is encoded.
   always_comb begin
      take      = 1'b0;
      kc_change = 1'b0;
      zrun_base = zrun;
      nnz_base  = nnz;
      case (state)
         ST_IDLE: begin
            take      = active;
            zrun_base = '0;
            nnz_base  = '0;
         end
         ST_STREAM: begin
            take      = active;
            kc_change = active && (bus.pool_kc != cur_kc);
            if (kc_change) begin
               zrun_base = '0;
               nnz_base  = '0;
            end
         end
         default: ;
      endcase
   end

   assign enc_in = take ? bus.pool_in : '0;

   ppu_lane_compactor #(
      .LANES  (LANES),
      .DATA_W (DATA_W),
      .RUN_W  (RUN_W),
      .CNT_W  (CNT_W)
   ) u_compactor (
      .pkt      (enc_in),
      .zrun_in  (zrun_base),
      .ent      (enc_out),
      .cnt      (enc_cnt),
      .zrun_out (zrun_enc)
   );

   assign nnz_sum = {1'b0, nnz_base} + (NNZ_W + 1)'(enc_cnt);
   assign nnz_sat = nnz_sum[NNZ_W];
   assign nnz_acc = nnz_sat ? '1 : nnz_sum[NNZ_W-1:0];

   // Next state and next registered outputs. Change plus finish in one cycle
   // goes through CLOSE so the freshly opened channel gets its own chan_done.
   always_comb begin
      state_n         = state;
      zrun_n          = zrun;
      nnz_n           = nnz;
      cur_kc_n        = cur_kc;
      comp_out_n      = '0;
      comp_cnt_n      = '0;
      chan_done_n     = 1'b0;
      chan_kc_n       = '0;
      chan_nnz_n      = '0;
      compress_done_n = 1'b0;
      err_set         = 1'b0;
      case (state)
         ST_IDLE, ST_STREAM: begin
            comp_out_n = enc_out;
            comp_cnt_n = enc_cnt;
            zrun_n     = zrun_enc;
            nnz_n      = nnz_acc;
            err_set    = nnz_sat;
            if (take) begin
               cur_kc_n = bus.pool_kc;
               state_n  = ST_STREAM;
            end
            if (kc_change) begin
               chan_done_n = 1'b1;
               chan_kc_n   = cur_kc;
               chan_nnz_n  = nnz;
            end
            if (bus.pool_finish) begin
               if (kc_change) begin
                  state_n = ST_CLOSE;
               end else begin
                  state_n = ST_DONE;
                  if (take || (state == ST_STREAM)) begin
                     chan_done_n = 1'b1;
                     chan_kc_n   = cur_kc_n;
                     chan_nnz_n  = nnz_acc;
                  end
               end
            end
         end
         ST_CLOSE: begin
            chan_done_n = 1'b1;
            chan_kc_n   = cur_kc;
            chan_nnz_n  = nnz;
            err_set     = active;
            zrun_n      = '0;
            nnz_n       = '0;
            state_n     = ST_DONE;
         end
         ST_DONE: begin
            compress_done_n = 1'b1;
            err_set         = active;
            zrun_n          = '0;
            nnz_n           = '0;
            state_n         = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State, channel tracking and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= ST_IDLE;
         zrun              <= '0;
         nnz               <= '0;
         cur_kc            <= '0;
         bus.comp_out      <= '0;
         bus.comp_cnt      <= '0;
         bus.chan_done     <= 1'b0;
         bus.chan_kc       <= '0;
         bus.chan_nnz      <= '0;
         bus.compress_done <= 1'b0;
         bus.proto_err     <= 1'b0;
      end else begin
         state             <= state_n;
         zrun              <= zrun_n;
         nnz               <= nnz_n;
         cur_kc            <= cur_kc_n;
         bus.comp_out      <= comp_out_n;
         bus.comp_cnt      <= comp_cnt_n;
         bus.chan_done     <= chan_done_n;
         bus.chan_kc       <= chan_kc_n;
         bus.chan_nnz      <= chan_nnz_n;
         bus.compress_done <= compress_done_n;
         bus.proto_err     <= bus.proto_err | err_set;
      end
   end

endmodule

// File: tb/tb_ppu_sparse_compressor.sv
// Directed bench for ppu_sparse_compressor with a per-cycle scoreboard.
module tb_ppu_sparse_compressor;
   import ppu_sparse_compressor_pkg::*;

   typedef struct packed {
      PPU_COMP_OUT_PACKET    comp_out;
      logic [PPU_CNT_W-1:0]  comp_cnt;
      logic                  chan_done;
      logic [PPU_KC_W-1:0]   chan_kc;
      logic [PPU_NNZ_W-1:0]  chan_nnz;
      logic                  compress_done;
      logic                  proto_err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   exp_t q[$];

   int                   m_st;
   logic [3:0]           m_z;
   int                   m_nnz;
   logic [PPU_KC_W-1:0]  m_kc;
   logic                 m_err;

   ppu_sparse_compressor_if bus ();

   ppu_sparse_compressor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.pool_in = '0;
      bus.pool_kc = '0;
      bus.pool_finish = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_comp_out", 128'(bus.comp_out), 128'(0));
      chk("rst_comp_cnt", 128'(bus.comp_cnt), 128'(0));
      chk("rst_chan_done", 128'(bus.chan_done), 128'(0));
      chk("rst_chan_kc", 128'(bus.chan_kc), 128'(0));
      chk("rst_chan_nnz", 128'(bus.chan_nnz), 128'(0));
      chk("rst_compress_done", 128'(bus.compress_done), 128'(0));
      chk("rst_proto_err", 128'(bus.proto_err), 128'(0));
      rst = 1'b0;
      m_st = 0; m_z = '0; m_nnz = 0; m_kc = '0; m_err = 1'b0;
      q.delete();
   endtask

   // Reference: encode one packet into e, advancing the model run counter.
   task automatic model_encode(input logic [3:0] v, input logic [3:0][15:0] d,
                               inout exp_t e, output int n);
      logic [1:0] k;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) begin
            if (d[i] != 16'd0 || m_z == 4'd15) begin
               k = 2'(n);
               e.comp_out.valid[k] = 1'b1;
               e.comp_out.data[k]  = d[i];
               e.comp_out.run[k]   = (d[i] != 16'd0) ? m_z : 4'd15;
               n++;
               m_z = 4'd0;
            end else begin
               m_z = m_z + 4'd1;
            end
         end
      end
   endtask

   task automatic step(input logic [3:0] v, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3,
                       input logic [PPU_KC_W-1:0] kc, input logic fin);
      exp_t              e, got;
      logic [3:0][15:0]  d;
      logic              active, changed;
      int                n;
      d = {d3, d2, d1, d0};
      e = '0;
      n = 0;
      active = |v;
      changed = 1'b0;
      case (m_st)
         0, 1: begin
            changed = (m_st == 1) && active && (kc != m_kc);
            if (changed) begin
               e.chan_done = 1'b1; e.chan_kc = m_kc; e.chan_nnz = 16'(m_nnz);
            end
            if (m_st == 0 || changed) begin
               m_z = '0; m_nnz = 0;
            end
            if (active) begin
               m_kc = kc;
               model_encode(v, d, e, n);
               m_nnz += n;
               e.comp_cnt = PPU_CNT_W'(n);
               m_st = 1;
            end
            if (fin) begin
               if (changed) m_st = 2;
               else begin
                  if (m_st == 1) begin
                     e.chan_done = 1'b1; e.chan_kc = m_kc; e.chan_nnz = 16'(m_nnz);
                  end
                  m_st = 3;
               end
            end
         end
         2: begin
            e.chan_done = 1'b1; e.chan_kc = m_kc; e.chan_nnz = 16'(m_nnz);
            if (active) m_err = 1'b1;
            m_z = '0; m_nnz = 0; m_st = 3;
         end
         default: begin
            e.compress_done = 1'b1;
            if (active) m_err = 1'b1;
            m_st = 0;
         end
      endcase
      e.proto_err = m_err;
      q.push_back(e);
      bus.pool_in.valid = v;
      bus.pool_in.data  = d;
      bus.pool_kc       = kc;
      bus.pool_finish   = fin;
      @(posedge clk);
      #1;
      bus.pool_in = '0;
      bus.pool_finish = 1'b0;
      if (q.size() == 0) begin
         total++; bad++;
         $error("FAIL sb_empty observed=0 expected=1");
      end else begin
         got = q.pop_front();
         chk("sb_comp_out", 128'(bus.comp_out), 128'(got.comp_out));
         chk("sb_comp_cnt", 128'(bus.comp_cnt), 128'(got.comp_cnt));
         chk("sb_chan_done", 128'(bus.chan_done), 128'(got.chan_done));
         chk("sb_chan_kc", 128'(bus.chan_kc), 128'(got.chan_kc));
         chk("sb_chan_nnz", 128'(bus.chan_nnz), 128'(got.chan_nnz));
         chk("sb_compress_done", 128'(bus.compress_done), 128'(got.compress_done));
         chk("sb_proto_err", 128'(bus.proto_err), 128'(got.proto_err));
      end
   endtask

   task automatic idle();
      step(4'h0, 16'd0, 16'd0, 16'd0, 16'd0, '0, 1'b0);
   endtask

   initial begin
      do_reset();

      // Basic encode
      step(4'hF, 16'd5, 16'd0, 16'd0, 16'd7, 6'd0, 1'b0);
      chk("basic_cnt", 128'(bus.comp_cnt), 128'(2));
      chk("basic_valid", 128'(bus.comp_out.valid), 128'(4'b0011));
      chk("basic_e0", 128'({bus.comp_out.data[0], bus.comp_out.run[0]}), 128'({16'd5, 4'd0}));
      chk("basic_e1", 128'({bus.comp_out.data[1], bus.comp_out.run[1]}), 128'({16'd7, 4'd2}));
      step(4'h0, 16'd0, 16'd0, 16'd0, 16'd0, 6'd0, 1'b1);
      chk("fin_chan_done", 128'(bus.chan_done), 128'(1));
      chk("fin_chan_nnz", 128'(bus.chan_nnz), 128'(2));
      idle();
      chk("fin_compress_done", 128'(bus.compress_done), 128'(1));
      idle();

      // Run saturation: 20 zeros then a 9
      for (int i = 0; i < 5; i++) begin
         step(4'hF, 16'd0, 16'd0, 16'd0, 16'd0, 6'd0, 1'b0);
         if (i == 3) begin
            chk("sat_cnt", 128'(bus.comp_cnt), 128'(1));
            chk("sat_placeholder", 128'({bus.comp_out.data[0], bus.comp_out.run[0]}), 128'({16'd0, 4'd15}));
         end
      end
      step(4'h1, 16'd9, 16'd0, 16'd0, 16'd0, 6'd0, 1'b0);
      chk("sat_nine", 128'({bus.comp_out.data[0], bus.comp_out.run[0]}), 128'({16'd9, 4'd4}));
      step(4'hF, 16'd0, 16'd4, 16'd0, 16'd0, 6'd1, 1'b0);
      chk("sat_close_nnz", 128'(bus.chan_nnz), 128'(2));
      chk("sat_close_kc", 128'(bus.chan_kc), 128'(0));

      // Channel change
      step(4'hF, 16'd3, 16'd0, 16'd0, 16'd0, 6'd0, 1'b0);
      step(4'hF, 16'd0, 16'd4, 16'd0, 16'd0, 6'd1, 1'b0);
      chk("chg_done", 128'(bus.chan_done), 128'(1));
      chk("chg_nnz", 128'(bus.chan_nnz), 128'(1));
      chk("chg_entry", 128'({bus.comp_out.data[0], bus.comp_out.run[0]}), 128'({16'd4, 4'd1}));

      // Channel change together with finish: two back-to-back chan_done
      step(4'hF, 16'd1, 16'd2, 16'd0, 16'd0, 6'd2, 1'b1);
      chk("cf_first_kc", 128'(bus.chan_kc), 128'(1));
      chk("cf_cnt", 128'(bus.comp_cnt), 128'(2));
      idle();
      chk("cf_second_kc", 128'(bus.chan_kc), 128'(2));
      chk("cf_second_nnz", 128'(bus.chan_nnz), 128'(2));
      idle();
      chk("cf_compress_done", 128'(bus.compress_done), 128'(1));
      idle();

      // Finish with packet in the same channel
      step(4'hF, 16'd0, 16'd0, 16'd0, 16'd0, 6'd2, 1'b0);
      step(4'hF, 16'd1, 16'd2, 16'd0, 16'd0, 6'd2, 1'b1);
      chk("fp_cnt", 128'(bus.comp_cnt), 128'(2));
      chk("fp_run", 128'(bus.comp_out.run[0]), 128'(4));
      chk("fp_nnz", 128'(bus.chan_nnz), 128'(2));
      idle();
      chk("fp_compress_done", 128'(bus.compress_done), 128'(1));
      idle();

      // Finish while idle
      step(4'h0, 16'd0, 16'd0, 16'd0, 16'd0, 6'd0, 1'b1);
      chk("fi_no_chan_done", 128'(bus.chan_done), 128'(0));
      idle();
      chk("fi_compress_done", 128'(bus.compress_done), 128'(1));
      idle();

      // Packet during DONE is dropped and flags an error
      step(4'h0, 16'd0, 16'd0, 16'd0, 16'd0, 6'd0, 1'b1);
      step(4'hF, 16'd6, 16'd0, 16'd0, 16'd0, 6'd0, 1'b0);
      chk("err_dropped", 128'(bus.comp_cnt), 128'(0));
      chk("err_flag", 128'(bus.proto_err), 128'(1));
      idle();
      idle();
      chk("err_sticky", 128'(bus.proto_err), 128'(1));

      // Reset mid-stream
      step(4'hF, 16'd0, 16'd0, 16'd0, 16'd0, 6'd3, 1'b0);
      do_reset();
      step(4'hF, 16'd0, 16'd8, 16'd0, 16'd0, 6'd3, 1'b0);
      chk("rst_zrun_cleared", 128'({bus.comp_out.data[0], bus.comp_out.run[0]}), 128'({16'd8, 4'd1}));
      chk("rst_no_chan_done", 128'(bus.chan_done), 128'(0));
      step(4'h0, 16'd0, 16'd0, 16'd0, 16'd0, 6'd3, 1'b1);
      idle();
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
